// File: rtl/uart_byte_fifo_if.sv
// Byte-stream bus between a UART bus register file (master) and a byte FIFO (slave).
// Strobes are single-cycle requests; o_data/o_empty_n present the head byte.
interface uart_byte_fifo_if;
  logic        i_wr;
  logic [7:0]  i_data;
  logic        i_rd;
  logic        o_empty_n;
  logic [7:0]  o_data;
  logic [15:0] o_status;
  logic        o_err;

  // Handshake: a write is taken on any edge where i_wr is high and the FIFO is
  // not full (or is full with i_rd also high); a read pops on any edge where
  // i_rd and o_empty_n are both high. There is no ready back-pressure signal:
  // o_status[0] and o_empty_n serve as the ready/valid indications.
  modport master (
    output i_wr, i_data, i_rd,
    input  o_empty_n, o_data, o_status, o_err
  );

  modport slave (
    input  i_wr, i_data, i_rd,
    output o_empty_n, o_data, o_status, o_err
  );
endinterface

// File: rtl/uart_byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO for the UART RX/TX paths, with a
// bus status word (fill level or free space) and a sticky overflow flag.
module uart_byte_fifo #(
  parameter int LGFLEN = 4,
  parameter int RXFIFO = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  uart_byte_fifo_if.slave   bus
);

  localparam int DEPTH = 1 << LGFLEN;
  localparam logic [LGFLEN-1:0] MAX_FILL = '1;
  localparam logic [LGFLEN-1:0] HALF     = {1'b1, {(LGFLEN-1){1'b0}}};

  logic [7:0]        r_mem [DEPTH];
  logic [LGFLEN-1:0] r_wr_ptr;
  logic [LGFLEN-1:0] r_rd_ptr;
  logic              r_err;

  logic [LGFLEN-1:0] w_fill;
  logic [LGFLEN-1:0] w_level;
  logic              w_full;
  logic              w_empty;
  logic              w_do_wr;
  logic              w_do_rd;
  logic              w_overflow;
  logic [15:0]       w_status;

  assign w_fill  = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_fill == MAX_FILL);
  assign w_empty = (w_fill == '0);

  // A full FIFO still accepts a write when a pop frees a slot on the same edge.
  assign w_do_rd    = bus.i_rd && !w_empty;
  assign w_do_wr    = bus.i_wr && (!w_full || bus.i_rd);
  assign w_overflow = bus.i_wr && w_full && !bus.i_rd;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_do_wr)    r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd)    r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_overflow) r_err    <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset && w_do_wr) r_mem[r_wr_ptr] <= bus.i_data;
  end

  // RX reports bytes held, TX reports free slots; the half and ready bits are
  // then the same comparisons on whichever level is reported.
  assign w_level = (RXFIFO != 0) ? w_fill : (MAX_FILL - w_fill);

  always_comb begin
    w_status                = '0;
    w_status[15:12]         = 4'(LGFLEN);
    w_status[LGFLEN+1:2]    = w_level;
    w_status[1]             = (w_level >= HALF);
    w_status[0]             = (w_level != '0);
  end

  assign bus.o_empty_n = !w_empty;
  assign bus.o_data    = r_mem[r_rd_ptr];
  assign bus.o_status  = w_status;
  assign bus.o_err     = r_err;

endmodule

// File: tb/tb_uart_byte_fifo.sv
// Directed bench driving an RX-flavour and a TX-flavour FIFO with identical
// stimulus, checked against a queue model of the stored bytes.
module tb_uart_byte_fifo;

  logic i_clk;
  logic i_reset;

  uart_byte_fifo_if rx_if ();
  uart_byte_fifo_if tx_if ();

  uart_byte_fifo #(.LGFLEN(4), .RXFIFO(1)) u_rx (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (rx_if.slave)
  );

  uart_byte_fifo #(.LGFLEN(4), .RXFIFO(0)) u_tx (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (tx_if.slave)
  );

  // ---------------- clock ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  bit         m_err;
  int         checks;
  int         failures;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected status word for a 16-entry FIFO holding `fill` bytes.
  function automatic logic [15:0] exp_status(input int fill, input bit rx);
    int         lvl;
    logic [3:0] lvl4;
    lvl  = rx ? fill : (15 - fill);
    lvl4 = lvl[3:0];
    return {4'd4, 6'd0, lvl4, (lvl >= 8), (lvl != 0)};
  endfunction

  task automatic check_state(input string where);
    int fill;
    fill = exp_q.size();
    check({where, ":rx_empty_n"}, 16'(rx_if.o_empty_n), 16'(fill != 0));
    check({where, ":rx_status"},  rx_if.o_status, exp_status(fill, 1'b1));
    check({where, ":rx_err"},     16'(rx_if.o_err), 16'(m_err));
    check({where, ":tx_empty_n"}, 16'(tx_if.o_empty_n), 16'(fill != 0));
    check({where, ":tx_status"},  tx_if.o_status, exp_status(fill, 1'b0));
    check({where, ":tx_err"},     16'(tx_if.o_err), 16'(m_err));
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic wr, input logic [7:0] d, input logic rd);
    rx_if.i_wr = wr; rx_if.i_data = d; rx_if.i_rd = rd;
    tx_if.i_wr = wr; tx_if.i_data = d; tx_if.i_rd = rd;
  endtask

  // One clock with the given strobes; the model is updated from its pre-edge
  // state and read data is compared against the queue head before the edge.
  task automatic step(input logic wr, input logic [7:0] d, input logic rd);
    bit         do_rd;
    bit         do_wr;
    logic [7:0] e;
    do_rd = rd && (exp_q.size() != 0);
    do_wr = wr && ((exp_q.size() != 15) || rd);
    if (wr && rd == 1'b0 && exp_q.size() == 15) m_err = 1'b1;
    if (do_rd) begin
      e = exp_q.pop_front();
      check("rx_rd_data", 16'(rx_if.o_data), 16'(e));
      check("tx_rd_data", 16'(tx_if.o_data), 16'(e));
    end
    if (do_wr) exp_q.push_back(d);
    drive(wr, d, rd);
    @(posedge i_clk);
    #1;
    drive(1'b0, 8'h00, 1'b0);
    check_state("step");
  endtask

  task automatic do_reset(input logic wr, input logic rd);
    i_reset = 1'b1;
    drive(wr, 8'hEE, rd);
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    exp_q.delete();
    m_err = 1'b0;
    check_state("reset");
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    checks   = 0;
    failures = 0;
    m_err    = 1'b0;
    i_reset  = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    repeat (2) @(posedge i_clk);
    #1;
    do_reset(1'b0, 1'b0);
    check("rst_rx_status_const", rx_if.o_status, 16'h4000);
    check("rst_tx_status_const", tx_if.o_status, 16'h403F);

    // Single byte visible one cycle after the write, then popped.
    step(1'b1, 8'hA5, 1'b0);
    check("a5_data",      16'(rx_if.o_data), 16'h00A5);
    check("a5_level",     16'(rx_if.o_status[5:2]), 16'd1);
    check("a5_avail",     16'(rx_if.o_status[0]), 16'd1);
    check("a5_lgflen",    16'(rx_if.o_status[15:12]), 16'd4);
    step(1'b0, 8'h00, 1'b1);
    check("a5_popped",    16'(rx_if.o_empty_n), 16'd0);

    // Underflow read is ignored; write+read on empty keeps only the write.
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h33, 1'b1);
    check("wr_rd_empty_level", 16'(rx_if.o_status[5:2]), 16'd1);
    check("wr_rd_empty_data",  16'(rx_if.o_data), 16'h0033);
    step(1'b0, 8'h00, 1'b1);

    // Fill to capacity; half/ready bits walk through their thresholds.
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 8'(i), 1'b0);
      if (i == 6) check("half_before_8th", 16'(rx_if.o_status[1]), 16'd0);
      if (i == 7) begin
        check("half_at_8th",    16'(rx_if.o_status[1]), 16'd1);
        check("tx_free_at_8th", 16'(tx_if.o_status[5:2]), 16'd7);
        check("tx_half_at_8th", 16'(tx_if.o_status[1]), 16'd0);
      end
    end
    check("full_level",    16'(rx_if.o_status[5:2]), 16'd15);
    check("full_tx_ready", 16'(tx_if.o_status[0]), 16'd0);
    check("full_no_err",   16'(rx_if.o_err), 16'd0);

    // Full with simultaneous write+read: accepted, no error.
    step(1'b1, 8'h55, 1'b1);
    check("full_wr_rd_level", 16'(rx_if.o_status[5:2]), 16'd15);
    check("full_wr_rd_err",   16'(rx_if.o_err), 16'd0);

    // Overflow drops the byte and sets the sticky flag.
    step(1'b1, 8'hFF, 1'b0);
    check("ovf_err",   16'(rx_if.o_err), 16'd1);
    check("ovf_level", 16'(rx_if.o_status[5:2]), 16'd15);
    for (int i = 0; i < 14; i++) step(1'b0, 8'h00, 1'b1);
    check("last_byte", 16'(rx_if.o_data), 16'h0055);
    step(1'b0, 8'h00, 1'b1);
    check("err_sticky", 16'(rx_if.o_err), 16'd1);
    step(1'b0, 8'h00, 1'b1);

    // Clear the error, then stream 40 bytes at constant fill 3 across wraps.
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
    for (int i = 3; i < 43; i++) begin
      step(1'b1, 8'(8'h80 + i), 1'b1);
      if (i == 42) check("wrap_level", 16'(rx_if.o_status[5:2]), 16'd3);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);

    // Random bursts, then reset mid-operation with 5 bytes held.
    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
    check("pre_reset_level", 16'(rx_if.o_status[5:2]), 16'd5);
    do_reset(1'b1, 1'b1);
    check("post_reset_empty", 16'(rx_if.o_empty_n), 16'd0);
    check("post_reset_level", 16'(rx_if.o_status[5:2]), 16'd0);
    check("post_reset_err",   16'(rx_if.o_err), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
